pipeline_ctrl: RTL and testbench

//  Central stall/flush/bubble sequencer for the 5-stage pipeline. Drives the PC write enable,
//  the per-stage register load enables (pwrite1..pwrite4; 0 = register loads all-zero bubble)
//  and hold1..hold3 (register retains contents; overrides pwrite). Resolves load-use hazards,

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_detect.sv | 28 ++
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline control slice.
// State encoding and register-specifier width.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [2:0] {
    RUN,
    LD_STALL,
    MEM_WAIT,
    DRAIN,
    HALTED
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load
// and the source registers of the ID-stage instruction.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic [W-1:0] id_rs,
  input  logic [W-1:0] id_rt,
  input  logic         id_uses_rt,
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rd,
  output logic         lu_hazard
);

  logic rs_hit;
  logic rt_hit;

  // Register zero never carries a real dependency.
  always_comb begin
    rs_hit    = (ex_rd == id_rs);
    rt_hit    = id_uses_rt & (ex_rd == id_rt);
    lu_hazard = ex_mem_read
              & (ex_rd != '0)
              & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/bubble sequencer for the 5-stage pipeline.
// Load-use, memory wait, branch flush and halt drain.
module pipeline_ctrl #(
  parameter int REG_W        = pipe_pkg::REG_W,
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             pc_write,
  output logic             pwrite1,
  output logic             pwrite2,
  output logic             pwrite3,
  output logic             pwrite4,
  output logic             hold1,
  output logic             hold2,
  output logic             hold3,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  import pipe_pkg::*;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WC_W-1:0] WC_MAX =
    WC_W'(MEM_TIMEOUT);
  localparam logic [DC_W-1:0] DC_INIT =
    DC_W'(DRAIN_CYCLES);

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  state_t eff;

  logic [WC_W-1:0]  wait_q, wait_d;
  logic [DC_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             tmo_q, tmo_d;

  logic lu;
  logic lu_live;
  logic mem_wait;
  logic run_like;
  logic s_halted, s_wait, s_drain;
  logic s_flush, s_lu, s_halt;

  logic       pc_c;
  logic [4:1] pw_c;
  logic [3:1] hd_c;
  logic       halted_c;

  hazard_detect #(
    .W (REG_W)
  ) u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hazard   (lu)
  );

  // Mutually exclusive event selects, highest priority first.
  always_comb begin
    eff = (state_q == MEM_WAIT) ? ret_q : state_q;
    mem_wait = mem_access & ~mem_ready;
    s_halted = (eff == HALTED);
    s_wait   = ~s_halted & mem_wait;
    s_drain  = ~s_wait & (eff == DRAIN);
    run_like = ~s_wait
             & ((eff == RUN) | (eff == LD_STALL));
    lu_live  = lu & (eff != LD_STALL);
    s_flush  = run_like & branch_taken;
    s_lu     = run_like & ~branch_taken & lu_live;
    s_halt   = run_like & ~branch_taken
             & ~lu_live & halt;
  end

  // Next-state, counters and raw stage controls.
  always_comb begin
    state_d  = RUN;
    ret_d    = ret_q;
    wait_d   = '0;
    drain_d  = drain_q;
    tmo_d    = tmo_q;
    pc_c     = 1'b1;
    pw_c     = 4'b1111;
    hd_c     = 3'b000;
    halted_c = 1'b0;
    unique case (1'b1)
      s_halted: begin
        state_d  = HALTED;
        pc_c     = 1'b0;
        pw_c     = 4'b0000;
        halted_c = 1'b1;
      end
      s_wait: begin
        state_d = MEM_WAIT;
        ret_d   = (eff == DRAIN) ? DRAIN : RUN;
        pc_c    = 1'b0;
        pw_c[4] = 1'b0;
        hd_c    = 3'b111;
        wait_d  = (wait_q == WC_MAX)
                ? wait_q : wait_q + WC_W'(1);
        if (wait_d == WC_MAX) tmo_d = 1'b1;
      end
      s_drain: begin
        pc_c    = 1'b0;
        pw_c[1] = 1'b0;
        drain_d = drain_q - DC_W'(1);
        state_d = (drain_q == DC_W'(1))
                ? HALTED : DRAIN;
      end
      s_flush: begin
        pw_c[1] = 1'b0;
        pw_c[2] = 1'b0;
      end
      s_lu: begin
        state_d = LD_STALL;
        pc_c    = 1'b0;
        pw_c[2] = 1'b0;
        hd_c[1] = 1'b1;
      end
      s_halt: begin
        state_d = DRAIN;
        drain_d = DC_INIT;
      end
      default: ;
    endcase
    stall_d = stall_q;
    if (~s_halted & ~pc_c & (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  // Controls are forced low while reset is held.
  always_comb begin
    pc_write     = pc_c & rst_n;
    pwrite1      = pw_c[1] & rst_n;
    pwrite2      = pw_c[2] & rst_n;
    pwrite3      = pw_c[3] & rst_n;
    pwrite4      = pw_c[4] & rst_n;
    hold1        = hd_c[1] & rst_n;
    hold2        = hd_c[2] & rst_n;
    hold3        = hd_c[3] & rst_n;
    halted       = halted_c & rst_n;
    mem_timeout  = tmo_q;
    stall_cycles = stall_q;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      wait_q  <= '0;
      drain_q <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed cases then random
// traffic against a behavioural model of the rules.
module tb_pipeline_ctrl;

  localparam int RW  = 5;
  localparam int DC  = 3;
  localparam int MT  = 3;
  localparam int CW  = 6;
  localparam int SMX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read;
  logic          branch_taken, mem_access;
  logic          mem_ready, halt;
  logic          pc_write;
  logic          pwrite1, pwrite2, pwrite3, pwrite4;
  logic          hold1, hold2, hold3;
  logic          halted, mem_timeout;
  logic [CW-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Model: drain cycles left (0 = not draining),
  // current wait length, load-use mask, flags.
  int m_drain;
  int m_wlen;
  int m_stalls;
  bit m_mask;
  bit m_halted;
  bit m_tmo;

  pipeline_ctrl #(
    .REG_W        (RW),
    .DRAIN_CYCLES (DC),
    .MEM_TIMEOUT  (MT),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .halt         (halt),
    .pc_write     (pc_write),
    .pwrite1      (pwrite1),
    .pwrite2      (pwrite2),
    .pwrite3      (pwrite3),
    .pwrite4      (pwrite4),
    .hold1        (hold1),
    .hold2        (hold2),
    .hold3        (hold3),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs        = '0;
    id_rt        = '0;
    ex_rd        = '0;
    id_uses_rt   = 1'b0;
    ex_mem_read  = 1'b0;
    branch_taken = 1'b0;
    mem_access   = 1'b0;
    mem_ready    = 1'b0;
    halt         = 1'b0;
  endtask

  function automatic void model_reset();
    m_drain  = 0;
    m_wlen   = 0;
    m_stalls = 0;
    m_mask   = 1'b0;
    m_halted = 1'b0;
    m_tmo    = 1'b0;
  endfunction

  // Called just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_pc", pc_write, 0);
    chk("rst_pwrite",
        {pwrite4, pwrite3, pwrite2, pwrite1}, 0);
    chk("rst_hold", {hold3, hold2, hold1}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_tmo", mem_timeout, 0);
    chk("rst_stalls", stall_cycles, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: compare at the falling edge,
  // advance the model, return just after rising edge.
  task automatic step();
    bit       lu, w, nmask;
    bit       e_pc;
    bit [3:0] e_pw;
    bit [2:0] e_hd;
    @(negedge clk);
    lu = ex_mem_read && (ex_rd != 0) &&
         (ex_rd == id_rs ||
          (id_uses_rt && ex_rd == id_rt));
    w  = mem_access && !mem_ready;
    e_pc = 1'b1;
    e_pw = 4'b1111;
    e_hd = 3'b000;
    if (m_halted) begin
      e_pc = 1'b0;
      e_pw = 4'b0000;
    end else if (w) begin
      e_pc = 1'b0;
      e_pw = 4'b0111;
      e_hd = 3'b111;
    end else if (m_drain > 0) begin
      e_pc = 1'b0;
      e_pw = 4'b1110;
    end else if (branch_taken) begin
      e_pw = 4'b1100;
    end else if (lu && !m_mask) begin
      e_pc = 1'b0;
      e_pw = 4'b1101;
      e_hd = 3'b001;
    end
    chk("pc_write", pc_write, e_pc);
    chk("pwrite",
        {pwrite4, pwrite3, pwrite2, pwrite1}, e_pw);
    chk("hold", {hold3, hold2, hold1}, e_hd);
    chk("halted", halted, m_halted);
    chk("mem_timeout", mem_timeout, m_tmo);
    chk("stall_cycles", stall_cycles, m_stalls);
    if (!m_halted) begin
      if (!e_pc && m_stalls < SMX) m_stalls++;
      nmask = 1'b0;
      if (w) begin
        m_wlen++;
        if (m_wlen >= MT) m_tmo = 1'b1;
      end else begin
        m_wlen = 0;
        if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1'b1;
        end else if (branch_taken) begin
          nmask = 1'b0;
        end else if (lu && !m_mask) begin
          nmask = 1'b1;
        end else if (halt) begin
          m_drain = DC;
        end
      end
      m_mask = nmask;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    step();

    // load-use on rs: one stall, then masked
    ex_mem_read = 1'b1;
    ex_rd = 5'd5;
    id_rs = 5'd5;
    step();
    step();
    idle();

    // r0 load and unused rt: no stall
    ex_mem_read = 1'b1;
    step();
    ex_rd = 5'd7;
    id_rt = 5'd7;
    id_rs = 5'd3;
    step();
    idle();
    chk("t2_stalls", stall_cycles, 1);

    // four wait cycles, timeout after the third
    mem_access = 1'b1;
    repeat (2) step();
    chk("t3_tmo_early", mem_timeout, 0);
    repeat (2) step();
    mem_ready = 1'b1;
    step();
    chk("t3_stalls", stall_cycles, 5);
    chk("t3_tmo", mem_timeout, 1);
    idle();
    step();

    // branch beats a same-cycle load-use
    ex_mem_read  = 1'b1;
    ex_rd        = 5'd9;
    id_rs        = 5'd9;
    branch_taken = 1'b1;
    step();
    idle();
    step();

    // reset in the middle of a memory wait
    mem_access = 1'b1;
    repeat (2) step();
    do_reset();
    idle();
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs        = RW'($urandom_range(0, 7));
      id_rt        = RW'($urandom_range(0, 7));
      ex_rd        = RW'($urandom_range(0, 7));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      mem_access   = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      halt         = ($urandom_range(0, 60) == 0);
      if ((m_halted && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 400) == 0)
        do_reset();
      else
        step();
    end
    do_reset();
    idle();
    step();

    // halt drain with a two-cycle wait inside
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    mem_access = 1'b1;
    repeat (2) step();
    mem_access = 1'b0;
    repeat (2) step();
    chk("t5_halted", halted, 1);
    halt         = 1'b1;
    branch_taken = 1'b1;
    mem_access   = 1'b1;
    repeat (3) step();
    chk("t5_stalls", stall_cycles, 5);
    idle();

    // reset in the middle of a drain
    do_reset();
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    do_reset();
    step();
    chk("t6_halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
